alu: RTL and testbench



---
 rtl/alu_if.sv | 25 ++
 rtl/alu.sv | 97 +++++++++
 tb/tb_alu.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/alu_if.sv
// rtl/alu_if.sv - operand, opcode and result bundle between the execute stage and the alu
interface alu_if;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] c;
  logic [31:0] value;
  logic        highlow;
  logic        flag_a;
  logic        flag_b;
  logic [5:0]  opcode;
  logic [63:0] result;
  logic        flag_out;
  logic        addr_change;
  logic [63:0] new_addr;

  modport master (
    output a, b, c, value, highlow, flag_a, flag_b, opcode,
    input  result, flag_out, addr_change, new_addr
  );

  modport slave (
    input  a, b, c, value, highlow, flag_a, flag_b, opcode,
    output result, flag_out, addr_change, new_addr
  );
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 64-bit execute-stage alu with registered register/flag/address results
module alu_adder (
  input  logic [63:0] x,
  input  logic [63:0] y,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {64'd0, cin};
endmodule

module alu (
  input  logic  clk,
  input  logic  reset,
  alu_if.slave  bus
);
  localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1,  OP_AND = 6'd2,  OP_OR   = 6'd3;
  localparam logic [5:0] OP_XOR = 6'd4,  OP_LDI = 6'd5,  OP_MOV = 6'd6,  OP_STORE = 6'd7;
  localparam logic [5:0] OP_EQ  = 6'd8,  OP_LTU = 6'd9,  OP_LTS = 6'd10, OP_FAND = 6'd11;
  localparam logic [5:0] OP_FOR = 6'd12, OP_FNOT = 6'd13, OP_JMP = 6'd14, OP_JIF = 6'd15;
  localparam logic [5:0] OP_JR  = 6'd16;

  logic        is_sub;
  logic [63:0] adder_sum;
  logic        adder_cout_unused;

  logic [63:0] result_d;
  logic        flag_d;
  logic        change_d;
  logic [63:0] addr_d;

  // ADD and SUB share one adder; SUB feeds ~b with carry-in set
  assign is_sub = (bus.opcode == OP_SUB);

  alu_adder u_adder (
    .x    (bus.a),
    .y    (is_sub ? ~bus.b : bus.b),
    .cin  (is_sub),
    .sum  (adder_sum),
    .cout (adder_cout_unused)
  );

  always_comb begin
    result_d = 64'd0;
    flag_d   = 1'b0;
    change_d = 1'b0;
    addr_d   = 64'd0;
    case (bus.opcode)
      OP_ADD, OP_SUB: result_d = adder_sum;
      OP_AND:   result_d = bus.a & bus.b;
      OP_OR:    result_d = bus.a | bus.b;
      OP_XOR:   result_d = bus.a ^ bus.b;
      OP_LDI:   result_d = bus.highlow ? {bus.value, bus.a[31:0]} : {bus.a[63:32], bus.value};
      OP_MOV:   result_d = bus.a;
      OP_STORE: begin
        result_d = bus.c;
        addr_d   = bus.a;
      end
      OP_EQ:    flag_d = (bus.a == bus.b);
      OP_LTU:   flag_d = (bus.a < bus.b);
      OP_LTS:   flag_d = ($signed(bus.a) < $signed(bus.b));
      OP_FAND:  flag_d = bus.flag_a & bus.flag_b;
      OP_FOR:   flag_d = bus.flag_a | bus.flag_b;
      OP_FNOT:  flag_d = ~bus.flag_a;
      OP_JMP: begin
        flag_d   = bus.flag_a;
        change_d = 1'b1;
        addr_d   = {32'd0, bus.value};
      end
      OP_JIF: begin
        flag_d   = bus.flag_a;
        change_d = bus.flag_a;
        addr_d   = bus.flag_a ? {32'd0, bus.value} : 64'd0;
      end
      OP_JR: begin
        flag_d   = bus.flag_a;
        change_d = 1'b1;
        addr_d   = bus.a;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result      <= 64'd0;
      bus.flag_out    <= 1'b0;
      bus.addr_change <= 1'b0;
      bus.new_addr    <= 64'd0;
    end else begin
      bus.result      <= result_d;
      bus.flag_out    <= flag_d;
      bus.addr_change <= change_d;
      bus.new_addr    <= addr_d;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized and directed checks of alu against a behavioural model
module tb_alu;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  alu_if bus();

  alu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] result;
    logic        flag;
    logic        change;
    logic [63:0] addr;
  } out_t;

  out_t last_exp;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic out_t model(input logic [5:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [31:0] value, input logic hl,
                                 input logic fa, input logic fb);
    out_t o;
    logic [63:0] imm;
    o   = '0;
    imm = 64'(value);
    case (op)
      6'd0:  o.result = a + b;
      6'd1:  o.result = a - b;
      6'd2:  o.result = a & b;
      6'd3:  o.result = a | b;
      6'd4:  o.result = a ^ b;
      6'd5:  o.result = hl ? ((imm << 32) | (a & 64'h0000_0000_FFFF_FFFF))
                           : ((a & 64'hFFFF_FFFF_0000_0000) | imm);
      6'd6:  o.result = a;
      6'd7:  begin o.result = c; o.addr = a; end
      6'd8:  o.flag = (a == b);
      6'd9:  o.flag = (a < b);
      6'd10: o.flag = (a[63] != b[63]) ? a[63] : (a < b);
      6'd11: o.flag = fa && fb;
      6'd12: o.flag = fa || fb;
      6'd13: o.flag = !fa;
      6'd14: begin o.flag = fa; o.change = 1'b1; o.addr = imm; end
      6'd15: begin o.flag = fa; if (fa) begin o.change = 1'b1; o.addr = imm; end end
      6'd16: begin o.flag = fa; o.change = 1'b1; o.addr = a; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic compare_outputs(input string tag, input out_t e);
    check({tag, ".result"}, bus.result, e.result);
    check({tag, ".flag_out"}, 64'(bus.flag_out), 64'(e.flag));
    check({tag, ".addr_change"}, 64'(bus.addr_change), 64'(e.change));
    check({tag, ".new_addr"}, bus.new_addr, e.addr);
  endtask

  task automatic apply(input string tag, input logic rst, input logic [5:0] op,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [31:0] value, input logic hl, input logic fa, input logic fb);
    @(negedge clk);
    reset      = rst;
    bus.opcode = op;
    bus.a      = a;
    bus.b      = b;
    bus.c      = c;
    bus.value  = value;
    bus.highlow = hl;
    bus.flag_a = fa;
    bus.flag_b = fb;
    last_exp   = rst ? '0 : model(op, a, b, c, value, hl, fa, fb);
    @(posedge clk);
    #1;
    compare_outputs(tag, last_exp);
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = 6'd0; bus.a = '0; bus.b = '0; bus.c = '0;
    bus.value = '0; bus.highlow = 1'b0; bus.flag_a = 1'b0; bus.flag_b = 1'b0;

    apply("reset_add", 1'b1, 6'd0, 64'd5, 64'd7, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("reset_release", 1'b0, 6'd0, 64'd5, 64'd7, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    check("release_is_12", bus.result, 64'd12);
    apply("reset_over_jmp", 1'b1, 6'd14, 64'd9, 64'd9, 64'd9, 32'h40, 1'b0, 1'b1, 1'b1);

    apply("add_wrap", 1'b0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("sub_wrap", 1'b0, 6'd1, 64'd0, 64'd1, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("sub_10_3", 1'b0, 6'd1, 64'd10, 64'd3, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("xor", 1'b0, 6'd4, 64'hF0F0, 64'hFF00, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("ldi_low", 1'b0, 6'd5, 64'h1111_2222_3333_4444, 64'd0, 64'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    check("ldi_low_const", bus.result, 64'h1111_2222_DEAD_BEEF);
    apply("ldi_high", 1'b0, 6'd5, 64'h1111_2222_3333_4444, 64'd0, 64'd0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    check("ldi_high_const", bus.result, 64'hDEAD_BEEF_3333_4444);
    apply("ltu", 1'b0, 6'd9, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("lts", 1'b0, 6'd10, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("eq", 1'b0, 6'd8, 64'd42, 64'd42, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("jif_not_taken", 1'b0, 6'd15, 64'd0, 64'd0, 64'd0, 32'h40, 1'b0, 1'b0, 1'b0);
    apply("jif_taken", 1'b0, 6'd15, 64'd0, 64'd0, 64'd0, 32'h40, 1'b0, 1'b1, 1'b0);
    apply("jr", 1'b0, 6'd16, 64'h1234, 64'd0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("store", 1'b0, 6'd7, 64'h100, 64'd0, 64'hCAFE, 32'd0, 1'b0, 1'b0, 1'b0);
    apply("nop63", 1'b0, 6'd63, 64'h55, 64'h66, 64'h77, 32'h88, 1'b1, 1'b1, 1'b1);

    // outputs must not follow input changes between edges
    apply("hold_pre", 1'b0, 6'd16, 64'hABCD, 64'd0, 64'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    bus.opcode = 6'd0; bus.a = 64'd1; bus.b = 64'd2; bus.flag_a = 1'b0;
    #2;
    compare_outputs("hold_mid", last_exp);

    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra, rb, rc;
      logic [5:0]  rop;
      ra  = {$urandom, $urandom};
      rb  = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
      rc  = {$urandom, $urandom};
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(17, 63)) : 6'($urandom_range(0, 16));
      apply($sformatf("rand%0d_op%0d", i, rop), ($urandom_range(0, 29) == 0), rop, ra, rb, rc,
            $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
